// File: rtl/int_to_flop_if.sv
// Handshake bundle between an integer producer, the int_to_flop converter and
// the float-word consumer.
interface int_to_flop_if #(
  parameter int IN_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [12:0]     result;
  logic            overflow;
  logic            inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, overflow, inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, result, overflow, inexact
  );
endinterface

// File: rtl/int_to_flop.sv
// Signed integer to 13-bit float word {sign, exp[3:0], mant[7:0]}, normalising one bit per cycle.
// Optional macro INT2FLOP_ROUND_EN selects round-to-nearest-even instead of truncation.
module int_to_flop #(
  parameter int IN_W       = 16,
  parameter int EXP_OFFSET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  int_to_flop_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, PACK, OUT} state_t;

  state_t          r_state, w_next;
  logic [IN_W-1:0] r_mag;
  logic [3:0]      r_pos;
  logic            r_sign;
  logic            r_started;
  logic [12:0]     r_result;
  logic            r_ovf;
  logic            r_inx;

  logic            w_accept;
  logic [IN_W-1:0] w_abs;
  logic [IN_W+8:0] w_ext;
  logic [7:0]      w_mant;
  logic            w_guard;
  logic            w_sticky;
  logic [4:0]      w_exp;
  logic [7:0]      w_mant_f;
  logic [4:0]      w_exp_f;

  assign bus.in_ready  = (r_state == IDLE) && r_started;
  assign bus.out_valid = (r_state == OUT);
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.inexact   = r_inx;

  assign w_accept = bus.in_valid && bus.in_ready;
  // Two's-complement negate; the most negative input maps to 2^(IN_W-1) unsigned.
  assign w_abs    = bus.in_data[IN_W-1] ? (~bus.in_data + 1'b1) : bus.in_data;

  // Nine zero bits appended so guard/sticky indexing also works for IN_W == 9.
  assign w_ext    = {r_mag, 9'b0};
  assign w_mant   = w_ext[IN_W+7 -: 8];
  assign w_guard  = w_ext[IN_W-1];
  assign w_sticky = |w_ext[IN_W-2:0];
  assign w_exp    = {1'b0, r_pos} + 5'(EXP_OFFSET);

`ifdef INT2FLOP_ROUND_EN
  logic [8:0] w_rnd;
  assign w_rnd    = {1'b0, w_mant} + 9'(w_guard && (w_sticky || w_mant[0]));
  assign w_mant_f = w_rnd[7:0];
  assign w_exp_f  = w_exp + 5'(w_rnd[8]);
`else
  assign w_mant_f = w_mant;
  assign w_exp_f  = w_exp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NORM looks one shift ahead so the edge that sets the MSB also enters PACK.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_abs == '0)             w_next = OUT;
          else if (w_abs[IN_W-1])      w_next = PACK;
          else                         w_next = NORM;
        end
      end
      NORM: begin
        if (r_mag[IN_W-1] || r_mag[IN_W-2]) w_next = PACK;
      end
      PACK:    w_next = OUT;
      OUT: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      r_mag     <= '0;
      r_pos     <= '0;
      r_sign    <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_inx     <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= bus.in_data[IN_W-1];
            r_mag  <= w_abs;
            r_pos  <= 4'(IN_W-1);
            if (w_abs == '0) begin
              r_result <= '0;
              r_ovf    <= 1'b0;
              r_inx    <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!r_mag[IN_W-1]) begin
            r_mag <= r_mag << 1;
            r_pos <= r_pos - 4'd1;
          end
        end
        PACK: begin
          r_inx <= w_guard | w_sticky;
          if (w_exp_f > 5'd15) begin
            r_result <= {r_sign, 4'hF, 8'hFF};
            r_ovf    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_f[3:0], w_mant_f};
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
